// File: rtl/hid_fifo_bank.sv
// Multi-channel HID receive FIFO bank with memory-mapped pop-by-write access.
// Optional HID_FIFO_TIMESTAMP_EN stores a 32-bit cycle stamp with every entry.
module hid_fifo_bank #(
  parameter int NCHAN  = 2,
  parameter int DEPTH  = 16,
  parameter int DWIDTH = 9
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NCHAN-1:0]        in_ready,
  input  logic [NCHAN*DWIDTH-1:0] in_data,
  input  logic                    hid_en,
  input  logic [7:0]              hid_we,
  input  logic [8:0]              hid_addr,
  input  logic [63:0]             hid_wrdata,
  output logic [63:0]             hid_rddata,
  output logic                    irq_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  logic [2:0]       ch_sel;
  reg_sel_e         reg_sel;
  logic             bus_wr;
  logic [63:0]      data_word [NCHAN];
  logic [63:0]      stat_word [NCHAN];
  logic [NCHAN-1:0] irq_vec;
  logic [63:0]      rd_next;
  logic             unused_bits;

  assign ch_sel      = hid_addr[8:6];
  assign reg_sel     = reg_sel_e'(hid_addr[4:3]);
  assign bus_wr      = |hid_we;
  assign unused_bits = ^{hid_addr[5], hid_addr[2:0], hid_wrdata[63:3]};

`ifdef HID_FIFO_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_cnt <= '0;
    else         ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     cnt;
    logic [7:0]        ovf_cnt;
    logic              udf, irq_en, rdy_q;
    logic              sel, push_req, pop_req, ctrl_wr, flush, clr;
    logic              empty, full, do_push, do_pop, ovf_evt, udf_evt;
    logic [DWIDTH-1:0] head;
    logic [63:0]       dw;

    assign sel      = hid_en && (ch_sel == 3'(c));
    assign push_req = in_ready[c] && !rdy_q;
    assign pop_req  = sel && bus_wr && (reg_sel == REG_DATA);
    assign ctrl_wr  = sel && bus_wr && (reg_sel == REG_CTRL);
    assign flush    = ctrl_wr && hid_wrdata[2];
    assign clr      = ctrl_wr && hid_wrdata[1];
    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));

    // A pop on a full FIFO frees the slot the concurrent push lands in.
    assign do_pop  = pop_req && !empty;
    assign do_push = push_req && !flush && (!full || do_pop);
    assign ovf_evt = push_req && !flush && full && !do_pop;
    assign udf_evt = pop_req && empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdy_q   <= 1'b0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        cnt     <= '0;
        ovf_cnt <= '0;
        udf     <= 1'b0;
        irq_en  <= 1'b0;
      end else begin
        rdy_q <= in_ready[c];
        if (flush) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          cnt    <= '0;
        end else begin
          if (do_push) wr_ptr <= wr_ptr + PW'(1);
          if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
          cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
        if (clr)                             ovf_cnt <= '0;
        else if (ovf_evt && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        if (clr)          udf <= 1'b0;
        else if (udf_evt) udf <= 1'b1;
        if (ctrl_wr) irq_en <= hid_wrdata[0];
      end
    end

    always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= in_data[c*DWIDTH +: DWIDTH];
    end

    assign head = empty ? '0 : mem[rd_ptr];

`ifdef HID_FIFO_TIMESTAMP_EN
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge clk_i) begin
      if (do_push) ts_mem[wr_ptr] <= ts_cnt;
    end
`endif

    always_comb begin
      dw                = '0;
      dw[DWIDTH-1:0]    = head;
      dw[16]            = empty;
      dw[17]            = full;
`ifdef HID_FIFO_TIMESTAMP_EN
      dw[63:32]         = empty ? '0 : ts_mem[rd_ptr];
`endif
    end

    assign data_word[c] = dw;
    assign stat_word[c] = {46'd0, irq_en, udf, ovf_cnt, 8'(cnt)};
    assign irq_vec[c]   = irq_en && !empty;
  end

  always_comb begin
    rd_next = '0;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      if (32'(ch_sel) == c) begin
        case (reg_sel)
          REG_DATA:            rd_next = data_word[c];
          REG_STATUS, REG_CTRL: rd_next = stat_word[c];
          default:             rd_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hid_rddata <= '0;
      irq_o      <= 1'b0;
    end else begin
      if (hid_en && !bus_wr) hid_rddata <= rd_next;
      irq_o <= |irq_vec;
    end
  end

endmodule

// File: tb/tb_hid_fifo_bank.sv
// Directed self-checking bench for hid_fifo_bank (NCHAN=2, DEPTH=16, DWIDTH=9).
module tb_hid_fifo_bank;

  localparam int NCHAN  = 2;
  localparam int DEPTH  = 16;
  localparam int DWIDTH = 9;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NCHAN-1:0]        in_ready;
  logic [NCHAN*DWIDTH-1:0] in_data;
  logic                    hid_en;
  logic [7:0]              hid_we;
  logic [8:0]              hid_addr;
  logic [63:0]             hid_wrdata;
  logic [63:0]             hid_rddata;
  logic                    irq_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] tb_cyc;

  hid_fifo_bank #(.NCHAN(NCHAN), .DEPTH(DEPTH), .DWIDTH(DWIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_ready(in_ready), .in_data(in_data),
    .hid_en(hid_en), .hid_we(hid_we), .hid_addr(hid_addr),
    .hid_wrdata(hid_wrdata), .hid_rddata(hid_rddata), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  function automatic logic [8:0] mk_addr(input int ch, input int r);
    return {3'(ch), 1'b0, 2'(r), 3'b000};
  endfunction

  task automatic bus_read(input int ch, input int r, output logic [63:0] d);
    @(negedge clk);
    hid_en = 1'b1; hid_we = 8'h00; hid_addr = mk_addr(ch, r);
    @(negedge clk);
    hid_en = 1'b0;
    d = hid_rddata;
  endtask

  task automatic bus_write(input int ch, input int r, input logic [63:0] wd);
    @(negedge clk);
    hid_en = 1'b1; hid_we = 8'hFF; hid_addr = mk_addr(ch, r); hid_wrdata = wd;
    @(negedge clk);
    hid_en = 1'b0; hid_we = 8'h00; hid_wrdata = '0;
  endtask

  task automatic push(input int ch, input logic [8:0] d);
    @(negedge clk);
    in_data[ch*DWIDTH +: DWIDTH] = d;
    in_ready[ch] = 1'b1;
    @(negedge clk);
    in_ready[ch] = 1'b0;
  endtask

  task automatic test_reset;
    logic [63:0] d;
    rst_n = 1'b0;
    in_ready = '0; in_data = '0; hid_en = 1'b0; hid_we = '0; hid_addr = '0; hid_wrdata = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (hid_rddata !== 64'd0 || irq_o !== 1'b0) begin
      fails++; $display("FAIL reset_outputs rddata=%h irq=%b want 0/0", hid_rddata, irq_o);
    end
    rst_n = 1'b1;
    bus_read(0, 1, d);
    tests++;
    if (d !== 64'd0) begin fails++; $display("FAIL reset_status got=%h want=0", d); end
  endtask

  task automatic test_single_push;
    logic [63:0] d;
    @(negedge clk);
    in_data[8:0] = 9'h11C; in_ready[0] = 1'b1;
    repeat (5) @(negedge clk);
    in_ready[0] = 1'b0;
    bus_read(0, 0, d);
    tests++;
    if (d !== 64'h11C) begin fails++; $display("FAIL single_data got=%h want=11c", d); end
    bus_read(0, 1, d);
    tests++;
    if (d !== 64'h1) begin fails++; $display("FAIL single_count got=%h want=1", d); end
    bus_write(0, 0, 64'd0);
    bus_read(0, 1, d);
    tests++;
    if (d !== 64'h0) begin fails++; $display("FAIL single_pop_status got=%h want=0", d); end
  endtask

  task automatic test_overflow;
    logic [63:0] d, exp;
    for (int i = 0; i < 20; i++) push(1, 9'(9'h020 + i));
    bus_read(1, 1, d);
    tests++;
    if (d !== 64'h0410) begin fails++; $display("FAIL ovf_status got=%h want=410", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(1, 0, d);
      exp = 64'(9'h020 + i) | ((i == 0) ? 64'h20000 : 64'h0);
      tests++;
      if (d !== exp) begin fails++; $display("FAIL fifo_order[%0d] got=%h want=%h", i, d, exp); end
      bus_write(1, 0, 64'd0);
    end
    bus_write(1, 0, 64'd0);
    bus_read(1, 1, d);
    tests++;
    if (d !== 64'h10400) begin fails++; $display("FAIL underflow_status got=%h want=10400", d); end
    bus_read(1, 0, d);
    tests++;
    if (d !== 64'h10000) begin fails++; $display("FAIL empty_data got=%h want=10000", d); end
  endtask

  task automatic test_irq_ctrl;
    logic [63:0] d;
    bus_write(0, 2, 64'h1);
    push(0, 9'h005);
    @(negedge clk);
    tests++;
    if (irq_o !== 1'b1) begin fails++; $display("FAIL irq_assert got=%b want=1", irq_o); end
    bus_write(0, 0, 64'd0);
    @(negedge clk);
    tests++;
    if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_deassert got=%b want=0", irq_o); end
    bus_write(1, 2, 64'h6);
    bus_read(1, 1, d);
    tests++;
    if (d !== 64'h0) begin fails++; $display("FAIL ctrl_clear got=%h want=0", d); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] d;
    bus_write(0, 2, 64'h2);
    for (int i = 0; i < 16; i++) push(0, 9'(9'h040 + i));
    @(negedge clk);
    in_data[8:0] = 9'h1AA; in_ready[0] = 1'b1;
    hid_en = 1'b1; hid_we = 8'h01; hid_addr = mk_addr(0, 0);
    @(negedge clk);
    in_ready[0] = 1'b0; hid_en = 1'b0; hid_we = 8'h00;
    bus_read(0, 1, d);
    tests++;
    if (d !== 64'h10) begin fails++; $display("FAIL full_pushpop_status got=%h want=10", d); end
    bus_read(0, 0, d);
    tests++;
    if (d !== 64'h20041) begin fails++; $display("FAIL full_pushpop_head got=%h want=20041", d); end
    bus_write(0, 2, 64'h4);
    @(negedge clk);
    in_data[8:0] = 9'h0AB; in_ready[0] = 1'b1;
    hid_en = 1'b1; hid_we = 8'h80; hid_addr = mk_addr(0, 0);
    @(negedge clk);
    in_ready[0] = 1'b0; hid_en = 1'b0; hid_we = 8'h00;
    bus_read(0, 1, d);
    tests++;
    if (d !== 64'h10001) begin fails++; $display("FAIL empty_pushpop_status got=%h want=10001", d); end
    bus_read(0, 0, d);
    tests++;
    if (d !== 64'h0AB) begin fails++; $display("FAIL empty_pushpop_data got=%h want=0ab", d); end
    @(negedge clk);
    in_data[8:0] = 9'h033; in_ready[0] = 1'b1;
    hid_en = 1'b1; hid_we = 8'hFF; hid_addr = mk_addr(0, 2); hid_wrdata = 64'h4;
    @(negedge clk);
    in_ready[0] = 1'b0; hid_en = 1'b0; hid_we = 8'h00; hid_wrdata = '0;
    bus_read(0, 1, d);
    tests++;
    if (d !== 64'h10000) begin fails++; $display("FAIL flush_push_status got=%h want=10000", d); end
    bus_write(0, 2, 64'h2);
  endtask

  task automatic test_bad_chan;
    logic [63:0] d;
    push(1, 9'h099);
    bus_read(1, 1, d);
    tests++;
    if (d !== 64'h1) begin fails++; $display("FAIL ch1_status_pre got=%h want=1", d); end
    bus_write(5, 0, 64'd0);
    bus_write(5, 2, 64'h7);
    tests++;
    if (hid_rddata !== 64'h1) begin fails++; $display("FAIL rddata_hold got=%h want=1", hid_rddata); end
    bus_read(5, 0, d);
    tests++;
    if (d !== 64'h0) begin fails++; $display("FAIL badchan_read got=%h want=0", d); end
    bus_read(1, 0, d);
    tests++;
    if (d !== 64'h099) begin fails++; $display("FAIL ch1_data_post got=%h want=099", d); end
    bus_read(1, 3, d);
    tests++;
    if (d !== 64'h0) begin fails++; $display("FAIL reserved_read got=%h want=0", d); end
    bus_write(1, 2, 64'h4);
  endtask

`ifdef HID_FIFO_TIMESTAMP_EN
  task automatic test_timestamp;
    logic [63:0] d;
    logic [31:0] stamp;
    while (tb_cyc < 32'd99) @(negedge clk);
    stamp = tb_cyc;
    in_data[8:0] = 9'h077; in_ready[0] = 1'b1;
    @(negedge clk);
    in_ready[0] = 1'b0;
    bus_read(0, 0, d);
    tests++;
    if (d !== {stamp, 32'h077}) begin
      fails++; $display("FAIL timestamp got=%h want=%h", d, {stamp, 32'h077});
    end
    bus_write(0, 2, 64'h4);
  endtask
`endif

  task automatic test_async_reset;
    logic [63:0] d;
    bus_write(0, 2, 64'h1);
    push(0, 9'h0F0);
    push(0, 9'h0F1);
    bus_read(0, 1, d);
    tests++;
    if (d !== 64'h20002) begin fails++; $display("FAIL pre_reset_status got=%h want=20002", d); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (hid_rddata !== 64'd0 || irq_o !== 1'b0) begin
      fails++; $display("FAIL async_reset rddata=%h irq=%b want 0/0", hid_rddata, irq_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(0, 0, d);
    tests++;
    if (d !== 64'h10000) begin fails++; $display("FAIL post_reset_data got=%h want=10000", d); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_overflow();
    test_irq_ctrl();
    test_back_to_back();
    test_bad_chan();
`ifdef HID_FIFO_TIMESTAMP_EN
    test_timestamp();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
